cnu_minsum_serial: RTL

Parametrised serial check node unit for the layered LDPC decoder. It accepts the DEGREE variable-to-check messages of one parity row, one per cycle, over a valid/ready stream. It computes offset min-sum check-to-variable messages and the row parity, then streams DEGREE output messages back in edge order. A ping-pong result bank lets the unit collect row N+1 while row N is still being emitted, which sustains one message per cycle in each direction.

---
 rtl/cnu_minsum_serial.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cnu_minsum_serial.sv
// ---------------------------------------------------------------------------
// cnu_minsum_serial
//   Serial offset min-sum check node unit for a layered LDPC decoder.
//   Collects DEGREE variable-to-check messages of one parity row (one per
//   beat), then streams DEGREE check-to-variable messages back in edge order.
//   A result bank separate from the collector lets row N+1 be collected while
//   row N is emitted, so both streams sustain one beat per cycle.
//
// Parameters
//   DEGREE  edges per row (2..64)
//   MAG_W   message magnitude width
//   OFFSET  offset subtracted from output magnitudes, saturating at 0
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_data    {hard, sign, magnitude[MAG_W-1:0]}
//   out_valid  output beat valid
//   out_ready  output beat accepted when out_valid && out_ready
//   out_data   {sign, magnitude[MAG_W-1:0]}
//   out_last   high on the beat for edge DEGREE-1
//   p_bit      XOR of the row's hard decisions, held for the whole row
// ---------------------------------------------------------------------------
module cnu_minsum_serial #(
    parameter int DEGREE = 6,
    parameter int MAG_W  = 4,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W+1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W:0]   out_data,
    output logic             out_last,
    output logic             p_bit
);

    localparam int              CW      = $clog2(DEGREE);
    localparam logic [CW-1:0]   LAST    = CW'(DEGREE - 1);
    localparam logic [MAG_W-1:0] MAG_MAX = '1;
    localparam logic [MAG_W-1:0] OFF     = MAG_W'(OFFSET);

    // Collector state
    logic [CW-1:0]    in_cnt_q, in_cnt_d;
    logic [MAG_W-1:0] min1_q, min1_d, min2_q, min2_d;
    logic [CW-1:0]    idx1_q, idx1_d;
    logic             sx_q, sx_d, par_q, par_d;
    logic [DEGREE-1:0] sv_q, sv_d;

    // Output bank state
    logic             full_q, full_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic [MAG_W-1:0] b_min1_q, b_min1_d, b_min2_q, b_min2_d;
    logic [CW-1:0]    b_idx1_q, b_idx1_d;
    logic             b_sx_q, b_sx_d, b_par_q, b_par_d;
    logic [DEGREE-1:0] b_sv_q, b_sv_d;

    // Collector values including the current beat
    logic [MAG_W-1:0] m;
    logic             s, h;
    logic [MAG_W-1:0] u_min1, u_min2;
    logic [CW-1:0]    u_idx1;
    logic             u_sx, u_par;
    logic [DEGREE-1:0] u_sv;

    logic in_fire, out_fire, out_done, row_done;

    assign m = in_data[MAG_W-1:0];
    assign s = in_data[MAG_W];
    assign h = in_data[MAG_W+1];

    assign out_fire = full_q && out_ready;
    assign out_done = out_fire && (out_cnt_q == LAST);
    // Only the final beat of a row needs the bank; it may enter in the same
    // cycle the bank drains its last beat.
    assign in_ready = !((in_cnt_q == LAST) && full_q && !out_done);
    assign in_fire  = in_valid && in_ready;
    assign row_done = in_fire && (in_cnt_q == LAST);

    always_comb begin
        u_min1 = min1_q;
        u_min2 = min2_q;
        u_idx1 = idx1_q;
        // Strict compares: a tie with min1 lands in min2, keeping idx1 at the
        // first occurrence of the minimum.
        if (m < min1_q) begin
            u_min2 = min1_q;
            u_min1 = m;
            u_idx1 = in_cnt_q;
        end else if (m < min2_q) begin
            u_min2 = m;
        end
        u_sx  = sx_q ^ s;
        u_par = par_q ^ h;
        u_sv  = sv_q;
        u_sv[in_cnt_q] = s;
    end

    always_comb begin
        in_cnt_d = in_cnt_q;
        min1_d   = min1_q;
        min2_d   = min2_q;
        idx1_d   = idx1_q;
        sx_d     = sx_q;
        par_d    = par_q;
        sv_d     = sv_q;
        if (in_fire) begin
            if (row_done) begin
                in_cnt_d = '0;
                min1_d   = MAG_MAX;
                min2_d   = MAG_MAX;
                idx1_d   = '0;
                sx_d     = 1'b0;
                par_d    = 1'b0;
                sv_d     = '0;
            end else begin
                in_cnt_d = in_cnt_q + CW'(1);
                min1_d   = u_min1;
                min2_d   = u_min2;
                idx1_d   = u_idx1;
                sx_d     = u_sx;
                par_d    = u_par;
                sv_d     = u_sv;
            end
        end
    end

    always_comb begin
        full_d    = full_q;
        out_cnt_d = out_cnt_q;
        b_min1_d  = b_min1_q;
        b_min2_d  = b_min2_q;
        b_idx1_d  = b_idx1_q;
        b_sx_d    = b_sx_q;
        b_par_d   = b_par_q;
        b_sv_d    = b_sv_q;
        if (out_fire) begin
            if (out_done) begin
                full_d    = 1'b0;
                out_cnt_d = '0;
            end else begin
                out_cnt_d = out_cnt_q + CW'(1);
            end
        end
        // A completed row reloads the bank; this wins over a simultaneous drain.
        if (row_done) begin
            full_d    = 1'b1;
            out_cnt_d = '0;
            b_min1_d  = u_min1;
            b_min2_d  = u_min2;
            b_idx1_d  = u_idx1;
            b_sx_d    = u_sx;
            b_par_d   = u_par;
            b_sv_d    = u_sv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_q  <= '0;
            min1_q    <= MAG_MAX;
            min2_q    <= MAG_MAX;
            idx1_q    <= '0;
            sx_q      <= 1'b0;
            par_q     <= 1'b0;
            sv_q      <= '0;
            full_q    <= 1'b0;
            out_cnt_q <= '0;
            b_min1_q  <= MAG_MAX;
            b_min2_q  <= MAG_MAX;
            b_idx1_q  <= '0;
            b_sx_q    <= 1'b0;
            b_par_q   <= 1'b0;
            b_sv_q    <= '0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            min1_q    <= min1_d;
            min2_q    <= min2_d;
            idx1_q    <= idx1_d;
            sx_q      <= sx_d;
            par_q     <= par_d;
            sv_q      <= sv_d;
            full_q    <= full_d;
            out_cnt_q <= out_cnt_d;
            b_min1_q  <= b_min1_d;
            b_min2_q  <= b_min2_d;
            b_idx1_q  <= b_idx1_d;
            b_sx_q    <= b_sx_d;
            b_par_q   <= b_par_d;
            b_sv_q    <= b_sv_d;
        end
    end

    // Output beat is decoded purely from bank registers.
    logic [MAG_W-1:0] sel_mag;
    logic [MAG_W:0]   diff;
    logic [MAG_W-1:0] off_mag;

    assign sel_mag = (out_cnt_q == b_idx1_q) ? b_min2_q : b_min1_q;
    // Borrow bit of the extended subtraction flags underflow -> clamp to 0.
    assign diff    = {1'b0, sel_mag} - {1'b0, OFF};
    assign off_mag = diff[MAG_W] ? '0 : diff[MAG_W-1:0];

    assign out_valid = full_q;
    assign out_data  = full_q ? {b_sx_q ^ b_sv_q[out_cnt_q], off_mag} : '0;
    assign out_last  = full_q && (out_cnt_q == LAST);
    assign p_bit     = full_q && b_par_q;

endmodule
